// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin front end that shares one divider among NUM_REQ
// requesters. Accepts one operand pair at a time, drives the divider's
// start/operand inputs, and returns the result tagged with the requester id.
// Optional feature: define DIVIDER_ARB_TIMEOUT_EN to add a BUSY-state timeout
// (parameter TIMEOUT_CYCLES) that completes with resp_error=1 and zero results.
module divider_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
`ifdef DIVIDER_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_quotient,
  output logic [WIDTH-1:0]         resp_remainder,
  output logic                     resp_error,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  output logic                     div_start,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  input  logic                     div_error,
  input  logic                     div_done
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;      // first index searched for the next grant
  logic [ID_W-1:0] cur_id;      // requester currently being served
  logic [ID_W-1:0] grant_id;
  logic            grant_found;
  logic [ID_W:0]   search_idx;  // one spare bit so rr_ptr + i cannot overflow

`ifdef DIVIDER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
`endif

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so no latch is inferred.
    grant_found = 1'b0;
    grant_id    = '0;
    search_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      search_idx = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (search_idx >= (ID_W + 1)'(NUM_REQ)) begin
        search_idx = search_idx - (ID_W + 1)'(NUM_REQ);
      end
      if (!grant_found && |(req_valid & (NUM_REQ'(1) << search_idx))) begin
        grant_found = 1'b1;
        grant_id    = search_idx[ID_W-1:0];
      end
    end
  end

  // One-hot ready toward the granted requester, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found && !reset) begin
      req_ready = NUM_REQ'(1) << grant_id;
    end
  end

  // Control FSM with registered divider-side and response-side outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every register here is a plain flop (no memory array), so all of them take the reset value.
      state          <= IDLE;
      rr_ptr         <= '0;
      cur_id         <= '0;
      div_dividend   <= '0;
      div_divisor    <= '0;
      div_start      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_id        <= '0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_error     <= 1'b0;
`ifdef DIVIDER_ARB_TIMEOUT_EN
      timer          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            cur_id       <= grant_id;
            div_dividend <= req_dividend[int'(grant_id)*WIDTH +: WIDTH];
            div_divisor  <= req_divisor[int'(grant_id)*WIDTH +: WIDTH];
            div_start    <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          // div_done is not looked at here; the divider only just saw start.
          div_start <= 1'b0;
          state     <= BUSY;
`ifdef DIVIDER_ARB_TIMEOUT_EN
          timer     <= '0;
`endif
        end
        BUSY: begin
          if (div_done) begin
            resp_quotient  <= div_quotient;
            resp_remainder <= div_remainder;
            resp_error     <= div_error;
            resp_id        <= cur_id;
            resp_valid     <= 1'b1;
            state          <= RESP;
          end
`ifdef DIVIDER_ARB_TIMEOUT_EN
          else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            // Give up on the divider; the next div_start restarts it.
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_error     <= 1'b1;
            resp_id        <= cur_id;
            resp_valid     <= 1'b1;
            state          <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
